// File: rtl/router_filereg_pkg.sv
// Shared message layout, command/status encodings and FSM states for the router file-register block.
package router_filereg_pkg;

   localparam int unsigned CMD_W      = 2;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned PAYLOAD_W  = 32;
   localparam int unsigned MSG_W      = CMD_W + REG_ADDR_W + PAYLOAD_W;

   localparam int unsigned PAYLOAD_LSB = 0;
   localparam int unsigned REG_LSB     = PAYLOAD_W;
   localparam int unsigned CMD_LSB     = PAYLOAD_W + REG_ADDR_W;

   localparam logic [CMD_W-1:0] CMD_WRITE = 2'b00;
   localparam logic [CMD_W-1:0] CMD_READ  = 2'b01;

   localparam logic [CMD_W-1:0] ST_WRITE_ACK = 2'b00;
   localparam logic [CMD_W-1:0] ST_READ_DATA = 2'b01;
   localparam logic [CMD_W-1:0] ST_ERR_ADDR  = 2'b10;
   localparam logic [CMD_W-1:0] ST_ERR_CMD   = 2'b11;

   // Request {cmd, reg, payload} and response {status, reg, data} share one layout.
   typedef struct packed {
      logic [CMD_W-1:0]      cmd;
      logic [REG_ADDR_W-1:0] reg_addr;
      logic [PAYLOAD_W-1:0]  payload;
   } filereg_msg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } filereg_state_t;

endpackage

// File: rtl/router_filereg_bank.sv
// Configuration register array: constant register 0, read-only masking, flattened view and update pulse.
module router_filereg_bank
   import router_filereg_pkg::*;
#(
   parameter int unsigned            NUM_REGS = 16,
   parameter logic [NUM_REGS-1:0]    RO_MASK  = NUM_REGS'(1),
   parameter logic [PAYLOAD_W-1:0]   ID_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [REG_ADDR_W-1:0]         wr_idx,
   input  logic [PAYLOAD_W-1:0]          wr_data,
   output logic [NUM_REGS*PAYLOAD_W-1:0] regs,
   output logic                          update,
   output logic [REG_ADDR_W-1:0]         update_idx
);

   logic wr_ok_c;

   // A write lands only on an implemented, writable register other than register 0.
   always_comb begin
      wr_ok_c = 1'b0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (wr_en && (wr_idx == REG_ADDR_W'(i)) && !RO_MASK[i]) wr_ok_c = 1'b1;
      end
   end

   assign regs[PAYLOAD_W-1:0] = ID_VALUE;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic [PAYLOAD_W-1:0] val_q;

      // Storage for one writable register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            val_q <= '0;
         end else if (wr_ok_c && (wr_idx == REG_ADDR_W'(g))) begin
            val_q <= wr_data;
         end
      end

      assign regs[g*PAYLOAD_W +: PAYLOAD_W] = val_q;
   end

   // Update pulse coincides with the new value becoming visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         update     <= 1'b0;
         update_idx <= '0;
      end else begin
         update <= wr_ok_c;
         if (wr_ok_c) update_idx <= wr_idx;
      end
   end

endmodule

// File: rtl/router_filereg_access_controller.sv
// Executes NoC file-register WRITE/READ requests one at a time and returns a routed response.
module router_filereg_access_controller
   import router_filereg_pkg::*;
#(
   parameter int unsigned          MODULE_ADDR_W = 11,
   parameter int unsigned          NUM_REGS      = 16,
   parameter logic [NUM_REGS-1:0]  RO_MASK       = NUM_REGS'(1),
   parameter logic [PAYLOAD_W-1:0] ID_VALUE      = 32'h0000_0000,
   parameter bit                   WRITE_ACK     = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          s_req_tvalid_i,
   output logic                          s_req_tready_o,
   input  logic [MSG_W-1:0]              s_req_tdata_i,
   input  logic [MODULE_ADDR_W-1:0]      s_req_tid_i,
   output logic                          m_rsp_tvalid_o,
   input  logic                          m_rsp_tready_i,
   output logic [MSG_W-1:0]              m_rsp_tdata_o,
   output logic [MODULE_ADDR_W-1:0]      m_rsp_tdest_o,
   output logic [NUM_REGS*PAYLOAD_W-1:0] cfg_regs_o,
   output logic                          cfg_update_o,
   output logic [REG_ADDR_W-1:0]         cfg_update_idx_o
);

   filereg_state_t             state_q, state_d;
   logic                       ready_q, ready_d;
   filereg_msg_t               req_q, req_d;
   logic [MODULE_ADDR_W-1:0]   tid_q, tid_d;
   logic                       rsp_valid_q, rsp_valid_d;
   filereg_msg_t               rsp_q, rsp_d;
   logic [MODULE_ADDR_W-1:0]   dest_q, dest_d;
   logic                       wr_en_c;
   logic                       addr_err_c;
   logic                       cmd_err_c;
   logic                       ro_hit_c;
   logic [PAYLOAD_W-1:0]       rd_data_c;

   // Decode the latched request: range, read-only target and read mux.
   always_comb begin
      addr_err_c = (32'(req_q.reg_addr) >= NUM_REGS);
      ro_hit_c   = (req_q.reg_addr == '0);
      rd_data_c  = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (req_q.reg_addr == REG_ADDR_W'(i)) begin
            if (RO_MASK[i]) ro_hit_c = 1'b1;
            rd_data_c = cfg_regs_o[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
      cmd_err_c = ((req_q.cmd != CMD_WRITE) && (req_q.cmd != CMD_READ)) ||
                  ((req_q.cmd == CMD_WRITE) && ro_hit_c);
   end

   // Next-state and registered-output logic; errors are resolved before any write.
   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      req_d       = req_q;
      tid_d       = tid_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      dest_d      = dest_q;
      wr_en_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_req_tvalid_i && ready_q) begin
               req_d   = filereg_msg_t'(s_req_tdata_i);
               tid_d   = s_req_tid_i;
               state_d = EXEC;
            end else begin
               ready_d = 1'b1;
            end
         end
         EXEC: begin
            state_d          = RESP;
            rsp_valid_d      = 1'b1;
            dest_d           = tid_q;
            rsp_d.reg_addr   = req_q.reg_addr;
            rsp_d.payload    = '0;
            if (addr_err_c) begin
               rsp_d.cmd = ST_ERR_ADDR;
            end else if (cmd_err_c) begin
               rsp_d.cmd = ST_ERR_CMD;
            end else if (req_q.cmd == CMD_WRITE) begin
               wr_en_c       = 1'b1;
               rsp_d.cmd     = ST_WRITE_ACK;
               rsp_d.payload = req_q.payload;
               if (!WRITE_ACK) begin
                  state_d     = IDLE;
                  ready_d     = 1'b1;
                  rsp_valid_d = 1'b0;
                  rsp_d       = rsp_q;
                  dest_d      = dest_q;
               end
            end else begin
               rsp_d.cmd     = ST_READ_DATA;
               rsp_d.payload = rd_data_c;
            end
         end
         RESP: begin
            if (m_rsp_tready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
               ready_d     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         req_q       <= '0;
         tid_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         dest_q      <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         req_q       <= req_d;
         tid_q       <= tid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         dest_q      <= dest_d;
      end
   end

   assign s_req_tready_o = ready_q;
   assign m_rsp_tvalid_o = rsp_valid_q;
   assign m_rsp_tdata_o  = rsp_q;
   assign m_rsp_tdest_o  = dest_q;

   router_filereg_bank #(
      .NUM_REGS (NUM_REGS),
      .RO_MASK  (RO_MASK),
      .ID_VALUE (ID_VALUE)
   ) u_bank (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .wr_en      (wr_en_c),
      .wr_idx     (req_q.reg_addr),
      .wr_data    (req_q.payload),
      .regs       (cfg_regs_o),
      .update     (cfg_update_o),
      .update_idx (cfg_update_idx_o)
   );

endmodule

// File: tb/tb_router_filereg_access_controller.sv
// Scoreboard bench: acked instance for the main flows, silent-write instance for back-to-back writes.
module tb_router_filereg_access_controller;
   import router_filereg_pkg::*;

   localparam int unsigned AW = 11;
   localparam int unsigned NR = 16;
   localparam logic [31:0] ID = 32'hCAFE_0001;

   typedef struct {
      logic [1:0]  st;
      logic [4:0]  r;
      logic [31:0] d;
      logic [AW-1:0] dest;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, rst_na_n;

   logic              req_valid, req_ready, rsp_valid, rsp_ready, upd;
   logic [MSG_W-1:0]  req_data, rsp_data;
   logic [AW-1:0]     req_tid, rsp_dest;
   logic [NR*32-1:0]  regs;
   logic [4:0]        upd_idx;

   logic              na_valid, na_ready, na_rsp_valid, na_upd;
   logic [MSG_W-1:0]  na_data, na_rsp_data;
   logic [AW-1:0]     na_tid, na_rsp_dest;
   logic [NR*32-1:0]  na_regs;
   logic [4:0]        na_upd_idx;

   exp_t        sb[$];
   logic [31:0] exp_regs [NR];
   int checks = 0, errors = 0;
   int rsp_cnt = 0, upd_cnt = 0, na_upd_cnt = 0, na_rsp_cnt = 0;

   always #5 clk = ~clk;

   router_filereg_access_controller #(
      .MODULE_ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(16'h0001), .ID_VALUE(ID), .WRITE_ACK(1'b1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .s_req_tvalid_i(req_valid), .s_req_tready_o(req_ready),
      .s_req_tdata_i(req_data), .s_req_tid_i(req_tid),
      .m_rsp_tvalid_o(rsp_valid), .m_rsp_tready_i(rsp_ready),
      .m_rsp_tdata_o(rsp_data), .m_rsp_tdest_o(rsp_dest),
      .cfg_regs_o(regs), .cfg_update_o(upd), .cfg_update_idx_o(upd_idx)
   );

   router_filereg_access_controller #(
      .MODULE_ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(16'h0001), .ID_VALUE(32'h0), .WRITE_ACK(1'b0)
   ) dut_na (
      .clk_i(clk), .rst_ni(rst_na_n),
      .s_req_tvalid_i(na_valid), .s_req_tready_o(na_ready),
      .s_req_tdata_i(na_data), .s_req_tid_i(na_tid),
      .m_rsp_tvalid_o(na_rsp_valid), .m_rsp_tready_i(1'b1),
      .m_rsp_tdata_o(na_rsp_data), .m_rsp_tdest_o(na_rsp_dest),
      .cfg_regs_o(na_regs), .cfg_update_o(na_upd), .cfg_update_idx_o(na_upd_idx)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input int i);
      return regs[i*32 +: 32];
   endfunction

   // Response monitor: every handshake pops and compares one scoreboard entry.
   always @(negedge clk) begin
      if (upd) upd_cnt++;
      if (na_upd) na_upd_cnt++;
      if (na_rsp_valid) na_rsp_cnt++;
      if (rsp_valid && rsp_ready) begin
         rsp_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_rsp", 64'(rsp_data), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_data", 64'(rsp_data), 64'({e.st, e.r, e.d}));
            check("rsp_dest", 64'(rsp_dest), 64'(e.dest));
         end
      end
   end

   task automatic expect_rsp(input logic [1:0] st, input logic [4:0] r, input logic [31:0] d,
                             input logic [AW-1:0] dest);
      exp_t e;
      e.st = st; e.r = r; e.d = d; e.dest = dest;
      sb.push_back(e);
   endtask

   // Drive one request and return one step after its handshake edge.
   task automatic send(input logic [1:0] cmd, input logic [4:0] r, input logic [31:0] pl,
                       input logic [AW-1:0] tid);
      bit hs = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = {cmd, r, pl}; req_tid = tid;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req_ready) begin hs = 1; break; end
      end
      check("req_accept", 64'(hs), 64'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'(0));
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++) check(tag, 64'(reg_of(i)), 64'(exp_regs[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int u0;
      rst_n = 1'b0; rst_na_n = 1'b0;
      req_valid = 1'b0; req_data = '0; req_tid = '0; rsp_ready = 1'b1;
      na_valid = 1'b0; na_data = '0; na_tid = '0;
      for (int i = 0; i < NR; i++) exp_regs[i] = (i == 0) ? ID : 32'h0;

      repeat (3) @(negedge clk);
      check("rst_tready", 64'(req_ready), 64'(0));
      check("rst_tvalid", 64'(rsp_valid), 64'(0));
      check("rst_tdata", 64'(rsp_data), 64'(0));
      check("rst_tdest", 64'(rsp_dest), 64'(0));
      check("rst_upd", 64'({upd, upd_idx}), 64'(0));
      check_regs("rst_regs");
      rst_n = 1'b1; rst_na_n = 1'b1;
      @(negedge clk);
      check("post_rst_tready", 64'(req_ready), 64'(1));

      // Write reg 3 with latency checks
      expect_rsp(ST_WRITE_ACK, 5'd3, 32'hDEADBEEF, 11'h05A);
      send(CMD_WRITE, 5'd3, 32'hDEADBEEF, 11'h05A);
      @(negedge clk);
      check("lat_t1_tvalid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      check("lat_t2_tvalid", 64'(rsp_valid), 64'(1));
      check("lat_t2_reg3", 64'(reg_of(3)), 64'(32'hDEADBEEF));
      check("lat_t2_upd", 64'({upd, upd_idx}), 64'({1'b1, 5'd3}));
      exp_regs[3] = 32'hDEADBEEF;
      drain();
      check("upd_cnt_w3", 64'(upd_cnt), 64'(1));

      // Reads, ID register, errors
      expect_rsp(ST_READ_DATA, 5'd3, 32'hDEADBEEF, 11'h011);
      send(CMD_READ, 5'd3, 32'h0, 11'h011); drain();
      expect_rsp(ST_READ_DATA, 5'd0, ID, 11'h012);
      send(CMD_READ, 5'd0, 32'h0, 11'h012); drain();
      expect_rsp(ST_ERR_CMD, 5'd0, 32'h0, 11'h013);
      send(CMD_WRITE, 5'd0, 32'h1, 11'h013); drain();
      check("upd_cnt_ro", 64'(upd_cnt), 64'(1));
      expect_rsp(ST_ERR_ADDR, 5'd16, 32'h0, 11'h014);
      send(CMD_READ, 5'd16, 32'h0, 11'h014); drain();
      expect_rsp(ST_ERR_ADDR, 5'd31, 32'h0, 11'h015);
      send(CMD_WRITE, 5'd31, 32'h5555_AAAA, 11'h015); drain();
      expect_rsp(ST_ERR_CMD, 5'd2, 32'h0, 11'h016);
      send(2'b10, 5'd2, 32'h1234, 11'h016); drain();
      expect_rsp(ST_ERR_CMD, 5'd2, 32'h0, 11'h017);
      send(2'b11, 5'd2, 32'h4321, 11'h017); drain();
      check("upd_cnt_err", 64'(upd_cnt), 64'(1));
      expect_rsp(ST_WRITE_ACK, 5'd15, 32'h0F0F_0F0F, 11'h7FF);
      send(CMD_WRITE, 5'd15, 32'h0F0F_0F0F, 11'h7FF); drain();
      exp_regs[15] = 32'h0F0F_0F0F;
      check_regs("regs_after_err");

      // Backpressure with a queued second request
      rsp_ready = 1'b0;
      expect_rsp(ST_READ_DATA, 5'd3, 32'hDEADBEEF, 11'h007);
      send(CMD_READ, 5'd3, 32'h0, 11'h007);
      req_valid = 1'b1; req_data = {CMD_READ, 5'd15, 32'h0}; req_tid = 11'h008;
      expect_rsp(ST_READ_DATA, 5'd15, 32'h0F0F_0F0F, 11'h008);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_tvalid", 64'(rsp_valid), 64'(1));
         check("bp_tdata", 64'(rsp_data), 64'({ST_READ_DATA, 5'd3, 32'hDEADBEEF}));
         check("bp_tready", 64'(req_ready), 64'(0));
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_no_early_accept", 64'(req_ready), 64'(0));
      @(negedge clk);
      check("bp_accept_after_hs", 64'(req_ready), 64'(1));
      @(posedge clk); #1 req_valid = 1'b0;
      drain();

      // Reset during RESP
      rsp_ready = 1'b0;
      u0 = rsp_cnt;
      send(CMD_READ, 5'd3, 32'h0, 11'h020);
      @(negedge clk); @(negedge clk);
      check("mid_tvalid", 64'(rsp_valid), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(rsp_valid), 64'(0));
      check("mid_rst_tdata", 64'(rsp_data), 64'(0));
      check("mid_rst_tdest", 64'(rsp_dest), 64'(0));
      check("mid_rst_tready", 64'(req_ready), 64'(0));
      for (int i = 1; i < NR; i++) exp_regs[i] = 32'h0;
      check_regs("mid_rst_regs");
      rsp_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_no_rsp", 64'(rsp_cnt), 64'(u0));
      expect_rsp(ST_READ_DATA, 5'd3, 32'h0, 11'h021);
      send(CMD_READ, 5'd3, 32'h0, 11'h021); drain();

      // Silent writes, back to back
      @(posedge clk); #1;
      na_valid = 1'b1; na_tid = 11'h033;
      for (int i = 1; i <= 4; i++) begin
         bit hs = 0;
         na_data = {CMD_WRITE, 5'(i), 32'h1000_0000 + 32'(i)};
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (na_ready) begin hs = 1; break; end
         end
         check("na_accept", 64'(hs), 64'(1));
         @(posedge clk); #1;
      end
      na_valid = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 4; i++)
         check("na_reg", 64'(na_regs[i*32 +: 32]), 64'(32'h1000_0000 + 32'(i)));
      check("na_upd_cnt", 64'(na_upd_cnt), 64'(4));
      check("na_no_rsp", 64'(na_rsp_cnt), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_filereg_access_controller.md
Name: router_filereg_access_controller

Overview:
- Serves configuration requests that arrive at a router over the NoC as 39-bit file-register messages.
- Owns the router's 16 x 32-bit configuration register file and executes WRITE/READ commands on it, one at a time.
- Returns one response message per request, routed back to the requesting module address.
- Sits between the router's local-port AXI-Stream ejection/injection interfaces and the router datapath, which consumes the register file contents.

Parameters:
- MODULE_ADDR_W, 11, width of source/destination module address (tid/tdest)
- CMD_W, 2, command field width
- REG_ADDR_W, 5, register address field width
- PAYLOAD_W, 32, payload/register width
- NUM_REGS, 16, implemented registers (indices 0..NUM_REGS-1)
- MSG_W, 39, message width = CMD_W+REG_ADDR_W+PAYLOAD_W
- RO_MASK, 16'h0001, bit i set = register i read-only
- ID_VALUE, 32'h0000_0000, reset/constant value of register 0
- WRITE_ACK, 1, 1 = writes produce an ack response, 0 = writes are silent

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_req_tvalid_i  in  1  request valid
- s_req_tready_o  out  1  request ready
- s_req_tdata_i  in  MSG_W  request {cmd[38:37], reg[36:32], payload[31:0]}
- s_req_tid_i  in  MODULE_ADDR_W  requester module address
- m_rsp_tvalid_o  out  1  response valid
- m_rsp_tready_i  in  1  response ready
- m_rsp_tdata_o  out  MSG_W  response {status[38:37], reg[36:32], data[31:0]}
- m_rsp_tdest_o  out  MODULE_ADDR_W  response destination (= latched tid)
- cfg_regs_o  out  NUM_REGS*PAYLOAD_W  flattened register file, reg i at [i*32 +: 32]
- cfg_update_o  out  1  one-cycle pulse when a register is written
- cfg_update_idx_o  out  REG_ADDR_W  index written, valid with cfg_update_o

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - s_req_tready_o=0 during reset, 1 in the first cycle after reset deassertion.
  - m_rsp_tvalid_o=0, m_rsp_tdata_o=0, m_rsp_tdest_o=0.
  - cfg_update_o=0, cfg_update_idx_o=0.
  - Register 0 = ID_VALUE; all other registers = 0.
- Commands:
  - 2'b00 WRITE, 2'b01 READ.
  - 2'b10 and 2'b11 are illegal.
- Status codes:
  - 2'b00 WRITE_ACK.
  - 2'b01 READ_DATA.
  - 2'b10 ERR_ADDR: reg >= NUM_REGS.
  - 2'b11 ERR_CMD: illegal command, or WRITE to an RO_MASK register.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: s_req_tready_o=1. On tvalid&tready, latch cmd/reg/payload/tid and go to EXEC.
  - EXEC: s_req_tready_o=0.
    - Address or command error: rsp data=0, status per error, go to RESP.
    - Legal WRITE: reg <= payload; cfg_update_o=1 for this cycle with idx. Then go to RESP if WRITE_ACK=1 (data=payload, status 00), else go to IDLE.
    - READ: data = reg value (register 0 reads ID_VALUE), status 01, go to RESP.
    - Error checks take priority over execution; an erroneous request never modifies the register file.
  - RESP: m_rsp_tvalid_o=1 with tdata/tdest held stable. On m_rsp_tready_i go to IDLE. The response's reg field echoes the request.
- Latency: request handshake at cycle T.
  - The written value appears on cfg_regs_o at T+2.
  - m_rsp_tvalid_o first asserts at T+2.
  - The next request is accepted at the earliest one cycle after the response handshake.
- Outstanding requests: one at a time. Backpressure on the response holds the FSM in RESP indefinitely with tready low.
- AXI-Stream rules: tvalid never deasserts without a handshake; tdata is stable while tvalid&!tready.
- Register file: registers with an RO_MASK bit set are never written. Register 0 is constant ID_VALUE.
- Reset mid-operation: an asserted rst_ni in any state aborts the transaction immediately; no response is emitted after reset.
- Width rule: full 5-bit reg compared against NUM_REGS; no truncation/aliasing.

Decomposition:
- Shared package router_filereg_pkg:
  - Constants CMD_WRITE/CMD_READ and status codes.
  - Field offset constants.
  - A packed struct for the message.
  - FSM state enum.
- Optional sub-module router_filereg_bank: register array with write port, RO mask, flattened output and update pulse. The controller holds the FSM and AXI-Stream logic.

Test Plan:
- Write then read: WRITE reg 3 = 0xDEADBEEF, tid=0x05A
  - Response status 00, data 0xDEADBEEF, tdest 0x05A at T+2.
  - cfg_regs_o[3] = 0xDEADBEEF; cfg_update_o pulses once with idx 3.
  - READ reg 3 returns status 01, data 0xDEADBEEF.
- ID register: READ reg 0 with ID_VALUE=0xCAFE0001 → status 01, data 0xCAFE0001. WRITE reg 0 = 0x1 → status 11, register unchanged, no cfg_update_o.
- Bad address and command:
  - READ reg 16 → status 10, data 0.
  - Command 2'b10 to reg 2 → status 11.
  - Neither modifies the register file.
- Backpressure: hold m_rsp_tready_i=0 for 10 cycles after a READ.
  - tvalid and tdata stay stable; s_req_tready_o stays 0.
  - A queued second request is accepted only after the response handshake.
- Reset mid-transaction: assert rst_ni low during RESP.
  - Outputs return to reset values asynchronously.
  - Register 3 returns to 0; no response appears after release.
- WRITE_ACK=0: back-to-back WRITEs to reg 1..4 produce no responses; all four registers are updated, with 4 update pulses.
